// File: rtl/sprite_layer_compositor_if.sv
// Pixel, descriptor-config and sprite-ROM signal bundle of the sprite layer compositor.
interface sprite_layer_compositor_if #(
    parameter int NUM_SPRITES = 4,
    parameter int COORD_WIDTH = 11,
    parameter int ADDR_WIDTH  = 16,
    parameter int CIDX_WIDTH  = 6,
    parameter int IDX_WIDTH   = 4
);
    logic                                  iValid;
    logic signed [COORD_WIDTH-1:0]         iX;
    logic signed [COORD_WIDTH-1:0]         iY;
    logic                                  iFrameStart;
    logic                                  iCfgWe;
    logic [IDX_WIDTH-1:0]                  iCfgIdx;
    logic [2:0]                            iCfgField;
    logic [15:0]                           iCfgData;
    logic [NUM_SPRITES*ADDR_WIDTH-1:0]     oSpriteAddr;
    logic [NUM_SPRITES*CIDX_WIDTH-1:0]     iSpriteCidx;
    logic [CIDX_WIDTH-1:0]                 iBgCidx;
    logic                                  oValid;
    logic [CIDX_WIDTH-1:0]                 oCidx;
    logic [NUM_SPRITES-1:0]                oHitMask;

    modport master (
        output iValid, iX, iY, iFrameStart, iCfgWe, iCfgIdx, iCfgField, iCfgData,
               iSpriteCidx, iBgCidx,
        input  oSpriteAddr, oValid, oCidx, oHitMask
    );

    modport slave (
        input  iValid, iX, iY, iFrameStart, iCfgWe, iCfgIdx, iCfgField, iCfgData,
               iSpriteCidx, iBgCidx,
        output oSpriteAddr, oValid, oCidx, oHitMask
    );
endinterface

// File: rtl/sprite_layer_compositor.sv
// N-sprite compositor: double-buffered descriptors, ROM addressing, priority merge
// over a background index (3-cycle latency) and per-frame sprite-0 overlap mask.
module sprite_layer_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int COORD_WIDTH = 11,
    parameter int SIZE_WIDTH  = 9,
    parameter int ADDR_WIDTH  = 16,
    parameter int CIDX_WIDTH  = 6,
    parameter int IDX_WIDTH   = 4
) (
    input logic                      iClock,
    input logic                      iResetN,
    sprite_layer_compositor_if.slave bus
);
    localparam int EW = COORD_WIDTH + 2;

    logic signed [COORD_WIDTH-1:0] sh_x_r    [NUM_SPRITES];
    logic signed [COORD_WIDTH-1:0] sh_y_r    [NUM_SPRITES];
    logic [SIZE_WIDTH-1:0]         sh_w_r    [NUM_SPRITES];
    logic [SIZE_WIDTH-1:0]         sh_h_r    [NUM_SPRITES];
    logic [ADDR_WIDTH-1:0]         sh_base_r [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]        sh_en_r;
    logic signed [COORD_WIDTH-1:0] ac_x_r    [NUM_SPRITES];
    logic signed [COORD_WIDTH-1:0] ac_y_r    [NUM_SPRITES];
    logic [SIZE_WIDTH-1:0]         ac_w_r    [NUM_SPRITES];
    logic [SIZE_WIDTH-1:0]         ac_h_r    [NUM_SPRITES];
    logic [ADDR_WIDTH-1:0]         ac_base_r [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]        ac_en_r;
    logic signed [COORD_WIDTH-1:0] nx_x_s    [NUM_SPRITES];
    logic signed [COORD_WIDTH-1:0] nx_y_s    [NUM_SPRITES];
    logic [SIZE_WIDTH-1:0]         nx_w_s    [NUM_SPRITES];
    logic [SIZE_WIDTH-1:0]         nx_h_s    [NUM_SPRITES];
    logic [ADDR_WIDTH-1:0]         nx_base_s [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]        nx_en_s;

    logic signed [EW-1:0]              px_s, py_s;
    logic signed [EW-1:0]              dx_s [NUM_SPRITES];
    logic signed [EW-1:0]              dy_s [NUM_SPRITES];
    logic [ADDR_WIDTH-1:0]             loc_s [NUM_SPRITES];
    logic [NUM_SPRITES-1:0]            in_s, in1_r, in2_r, opaque_s, hit_s, acc_r, hit_mask_r;
    logic [NUM_SPRITES*ADDR_WIDTH-1:0] addr_r;
    logic                              v1_r, v2_r, valid_r;
    logic [CIDX_WIDTH-1:0]             sel_s, cidx_r;

    function automatic logic signed [EW-1:0] sext(input logic signed [COORD_WIDTH-1:0] v);
        return {{2{v[COORD_WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [EW-1:0] zext(input logic [SIZE_WIDTH-1:0] v);
        return {{(EW-SIZE_WIDTH){1'b0}}, v};
    endfunction

    assign px_s = sext(bus.iX);
    assign py_s = sext(bus.iY);

    // Shadow set after this cycle's config write; it is also what a frame start commits.
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            nx_x_s[i]    = sh_x_r[i];
            nx_y_s[i]    = sh_y_r[i];
            nx_w_s[i]    = sh_w_r[i];
            nx_h_s[i]    = sh_h_r[i];
            nx_base_s[i] = sh_base_r[i];
            nx_en_s[i]   = sh_en_r[i];
            if (bus.iCfgWe && (bus.iCfgIdx == IDX_WIDTH'(i))) begin
                case (bus.iCfgField)
                    3'd0:    nx_x_s[i]    = COORD_WIDTH'(bus.iCfgData);
                    3'd1:    nx_y_s[i]    = COORD_WIDTH'(bus.iCfgData);
                    3'd2:    nx_w_s[i]    = SIZE_WIDTH'(bus.iCfgData);
                    3'd3:    nx_h_s[i]    = SIZE_WIDTH'(bus.iCfgData);
                    3'd4:    nx_base_s[i] = ADDR_WIDTH'(bus.iCfgData);
                    3'd5:    nx_en_s[i]   = bus.iCfgData[0];
                    default: nx_en_s[i]   = sh_en_r[i];
                endcase
            end else begin
                nx_en_s[i] = sh_en_r[i];
            end
        end
    end

    // Area test and ROM-local address per channel; offsets are exact at EW bits.
    always_comb begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
            dx_s[i]  = px_s - sext(ac_x_r[i]);
            dy_s[i]  = py_s - sext(ac_y_r[i]);
            in_s[i]  = bus.iValid && ac_en_r[i]
                     && (ac_w_r[i] != {SIZE_WIDTH{1'b0}}) && (ac_h_r[i] != {SIZE_WIDTH{1'b0}})
                     && !dx_s[i][EW-1] && (dx_s[i] < zext(ac_w_r[i]))
                     && !dy_s[i][EW-1] && (dy_s[i] < zext(ac_h_r[i]));
            loc_s[i] = ADDR_WIDTH'(dx_s[i]) + ADDR_WIDTH'(dy_s[i]) * ADDR_WIDTH'(ac_w_r[i]);
        end
    end

    // Priority merge (lowest index wins) and sprite-0 overlap detection.
    always_comb begin
        sel_s = bus.iBgCidx;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            opaque_s[i] = in2_r[i]
                        && (bus.iSpriteCidx[i*CIDX_WIDTH +: CIDX_WIDTH] != {CIDX_WIDTH{1'b0}});
            sel_s = opaque_s[i] ? bus.iSpriteCidx[i*CIDX_WIDTH +: CIDX_WIDTH] : sel_s;
        end
        hit_s = {NUM_SPRITES{1'b0}};
        for (int i = 1; i < NUM_SPRITES; i++) begin
            hit_s[i] = opaque_s[0] && opaque_s[i];
        end
    end

    // Descriptor banks: shadow follows config writes, active loads on frame start.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                sh_x_r[i]    <= {COORD_WIDTH{1'b0}};
                sh_y_r[i]    <= {COORD_WIDTH{1'b0}};
                sh_w_r[i]    <= {SIZE_WIDTH{1'b0}};
                sh_h_r[i]    <= {SIZE_WIDTH{1'b0}};
                sh_base_r[i] <= {ADDR_WIDTH{1'b0}};
                ac_x_r[i]    <= {COORD_WIDTH{1'b0}};
                ac_y_r[i]    <= {COORD_WIDTH{1'b0}};
                ac_w_r[i]    <= {SIZE_WIDTH{1'b0}};
                ac_h_r[i]    <= {SIZE_WIDTH{1'b0}};
                ac_base_r[i] <= {ADDR_WIDTH{1'b0}};
            end
            sh_en_r <= {NUM_SPRITES{1'b0}};
            ac_en_r <= {NUM_SPRITES{1'b0}};
        end else begin
            sh_x_r    <= nx_x_s;
            sh_y_r    <= nx_y_s;
            sh_w_r    <= nx_w_s;
            sh_h_r    <= nx_h_s;
            sh_base_r <= nx_base_s;
            sh_en_r   <= nx_en_s;
            if (bus.iFrameStart) begin
                ac_x_r    <= nx_x_s;
                ac_y_r    <= nx_y_s;
                ac_w_r    <= nx_w_s;
                ac_h_r    <= nx_h_s;
                ac_base_r <= nx_base_s;
                ac_en_r   <= nx_en_s;
            end else begin
                ac_en_r   <= ac_en_r;
            end
        end
    end

    // Pixel pipeline, output registers and per-frame hit accumulation.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            v1_r       <= 1'b0;
            v2_r       <= 1'b0;
            valid_r    <= 1'b0;
            in1_r      <= {NUM_SPRITES{1'b0}};
            in2_r      <= {NUM_SPRITES{1'b0}};
            addr_r     <= {(NUM_SPRITES*ADDR_WIDTH){1'b0}};
            cidx_r     <= {CIDX_WIDTH{1'b0}};
            acc_r      <= {NUM_SPRITES{1'b0}};
            hit_mask_r <= {NUM_SPRITES{1'b0}};
        end else begin
            v1_r    <= bus.iValid;
            in1_r   <= in_s;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                addr_r[i*ADDR_WIDTH +: ADDR_WIDTH] <= in_s[i] ? (ac_base_r[i] + loc_s[i])
                                                              : {ADDR_WIDTH{1'b0}};
            end
            v2_r    <= v1_r;
            in2_r   <= in1_r;
            valid_r <= v2_r;
            if (v2_r) begin
                cidx_r <= sel_s;
            end else begin
                cidx_r <= cidx_r;
            end
            if (bus.iFrameStart) begin
                hit_mask_r <= acc_r | hit_s;
                acc_r      <= {NUM_SPRITES{1'b0}};
            end else begin
                acc_r      <= acc_r | hit_s;
            end
        end
    end

    assign bus.oSpriteAddr = addr_r;
    assign bus.oValid      = valid_r;
    assign bus.oCidx       = cidx_r;
    assign bus.oHitMask    = hit_mask_r;
endmodule

// File: doc/sprite_layer_compositor.md
Name: sprite_layer_compositor

Overview:
Parametrised N-sprite pixel compositor for the VGA render path. It replaces hard-wired per-object area logic with a bank of runtime-programmable sprite descriptors. Descriptors are double-buffered and committed at frame boundaries. The block drives sprite ROM addresses and priority-merges ROM colour indices over a background index, producing one colour index per pixel at fixed latency. It also reports per-frame overlap of sprite 0 with every other sprite, for hardware collision detection.

Parameters:
NUM_SPRITES, 4, number of sprite channels (1..16); index 0 has highest priority
COORD_WIDTH, 11, signed width of sprite X/Y and pixel x/y
SIZE_WIDTH, 9, unsigned width of sprite W/H
ADDR_WIDTH, 16, sprite ROM address width per channel
CIDX_WIDTH, 6, colour index width; index 0 is transparent
IDX_WIDTH, 4, width of the config sprite-select field

Ports:
iClock  in  1  pixel clock; all state updates on rising edge
iResetN  in  1  asynchronous active-low reset
iValid  in  1  pixel strobe; iX/iY are valid this cycle
iX  in  COORD_WIDTH  signed pixel x
iY  in  COORD_WIDTH  signed pixel y
iFrameStart  in  1  one-cycle pulse; commits descriptors and publishes hit mask
iCfgWe  in  1  descriptor write strobe
iCfgIdx  in  IDX_WIDTH  sprite select
iCfgField  in  3  0=X, 1=Y, 2=W, 3=H, 4=BASE, 5=ENABLE(bit0); 6/7 ignored
iCfgData  in  16  write data; truncated or sign-handled to the field width
oSpriteAddr  out  NUM_SPRITES*ADDR_WIDTH  per-channel ROM address; channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
iSpriteCidx  in  NUM_SPRITES*CIDX_WIDTH  per-channel ROM data, returned one cycle after oSpriteAddr
iBgCidx  in  CIDX_WIDTH  background index, aligned with iSpriteCidx
oValid  out  1  oCidx valid
oCidx  out  CIDX_WIDTH  composited colour index
oHitMask  out  NUM_SPRITES  bit i set if sprite 0 and sprite i were both opaque on the same pixel in the last completed frame; bit 0 always 0

Behaviour:
- Reset: all shadow and active descriptors are zero, so all sprites are disabled. oValid=0, oCidx=0, oSpriteAddr=0, oHitMask=0, hit accumulator=0, pipeline valids=0.
- Config writes go to the shadow set only. Writes with iCfgIdx >= NUM_SPRITES or field 6/7 are ignored.
- X and Y take iCfgData[COORD_WIDTH-1:0] as signed. W, H and BASE are zero-extended or truncated to their field widths.
- On iFrameStart, active <= shadow. A write in the same cycle is included in the commit.
- The pixel sampled in the iFrameStart cycle still uses the old active set. iFrameStart must precede the first pixel of a frame by at least 1 cycle.
- Stage 0 (cycle t, iValid=1): for each channel i, compute in_i = EN & W!=0 & H!=0 & X<=x<X+W & Y<=y<Y+H. Compares are signed at COORD_WIDTH+2 bits with no overflow.
- Stage 0 address: local_i = (x-X) + (y-Y)*W. It is registered to oSpriteAddr_i = BASE + local_i, mod 2^ADDR_WIDTH, at t+1.
- Channels that are not in area output address 0.
- Stage 2 (t+2): iSpriteCidx and iBgCidx are sampled. opaque_i = in_i & cidx_i != 0.
- Stage 2 selection: the result is the lowest-index opaque channel's cidx; if no channel is opaque, it is iBgCidx.
- Stage 2 hit accumulation: acc[i] |= opaque_0 & opaque_i for i >= 1.
- oCidx and oValid are registered at t+3. Latency is exactly 3 cycles, with no backpressure. Bubbles (iValid=0) propagate as oValid=0, and oCidx holds its last value.
- On iFrameStart, oHitMask <= acc | this-cycle hits, and acc <= 0.
- Asynchronous reset mid-frame clears everything immediately. Pixels in flight are dropped, and no oValid is produced for them.

Test Plan:
- Reset: hold iResetN=0 while driving pixels -> oValid=0, oCidx=0, oHitMask=0. Release reset, sprites still disabled, feed iBgCidx=5 -> oCidx=5 exactly 3 cycles after each iValid.
- Addressing: sprite0 X=10, Y=20, W=4, H=2, BASE=100, EN=1, committed. Pixel (11,21) at t -> oSpriteAddr0=105 at t+1. Return cidx 7 at t+2 -> oCidx=7, oValid=1 at t+3. Pixel (14,21) -> address 0, output = bg.
- Transparency and priority: sprites 0 and 1 both cover (50,50). ROM0=0, ROM1=9 -> 9. ROM0=3, ROM1=9 -> 3. Both 0, bg=2 -> 2.
- Shadow commit: with sprite0 X=10 active, write X=200 -> pixel (11,20) still hits. After iFrameStart, (11,20) misses and (201,20) hits. A write in the same cycle as iFrameStart is active next pixel.
- Negative coordinates: X=-3, W=8, Y=0, H=1, BASE=0. Pixel (0,0) -> address 3; pixel (5,0) -> miss.
- Collision: frame with sprites 0 and 2 both opaque on one pixel, sprite 1 overlapping only transparently -> after iFrameStart oHitMask=4'b0100. The next frame, with no overlap, yields 4'b0000.
